imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a framed byte stream from a host and writes 19-bit instruction words into instruction memory at 12-bit word addresses.
- Holds the CPU (`cpu_hold`) for the duration of a load so the fetch path never reads a half-written program.
- Sits between the host byte link and the instruction memory write port. The datapath's fetch port is the reader of the same memory.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host byte link plus instruction-memory write port of the loader.
// Byte handshake: a byte transfers on a rising clk edge where in_valid && in_ready; in_data is held while in_valid is high and in_ready low.
interface imem_loader_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19
);
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_hold;
    logic               done;
    logic               err;
    logic [2:0]         dbg_state;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err, dbg_state
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err, dbg_state
    );
endinterface

// File: rtl/imem_loader.sv
// Frames a host byte stream into instruction-memory writes and holds the CPU
// while a load is in flight; XOR checksum and idle timeout guard each frame.
module imem_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ADDR_W    = 12,
    parameter int         INSTR_W   = 19,
    parameter int         TIMEOUT   = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PAY   = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4
    } state_t;

    state_t             state;
    logic [1:0]         hdr_idx;
    logic [1:0]         pay_idx;
    logic [3:0]         hi_nib;
    logic [7:0]         b0;
    logic [7:0]         b1;
    logic [11:0]        cnt;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         chk;
    logic [TW-1:0]      tmo;
    logic               rdy;
    logic               we_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [INSTR_W-1:0] wdata_q;
    logic               hold_q;
    logic               done_q;
    logic               err_q;

    logic               accept;
    logic [23:0]        word;
    logic [11:0]        hdr_val;

    assign accept  = bus.in_valid && rdy;
    assign word    = {b0, b1, bus.in_data};
    assign hdr_val = {hi_nib, bus.in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            hdr_idx <= '0;
            pay_idx <= '0;
            hi_nib  <= '0;
            b0      <= '0;
            b1      <= '0;
            cnt     <= '0;
            addr    <= '0;
            chk     <= '0;
            tmo     <= '0;
            rdy     <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            rdy    <= 1'b1;
            case (state)
                S_IDLE: begin
                    // Non-sync bytes are swallowed so the host can resynchronise.
                    if (accept && bus.in_data == SYNC_BYTE) begin
                        state   <= S_HDR;
                        hold_q  <= 1'b1;
                        err_q   <= 1'b0;
                        chk     <= '0;
                        hdr_idx <= '0;
                        tmo     <= '0;
                    end
                end
                S_HDR, S_PAY, S_CHK: begin
                    if (!accept) begin
                        if (tmo == TW'(TIMEOUT - 1)) begin
                            err_q  <= 1'b1;
                            hold_q <= 1'b0;
                            tmo    <= '0;
                            state  <= S_IDLE;
                        end else begin
                            tmo <= tmo + TW'(1);
                        end
                    end else begin
                        tmo <= '0;
                        if (state != S_CHK) chk <= chk ^ bus.in_data;
                        if (state == S_HDR) begin
                            hdr_idx <= hdr_idx + 2'd1;
                            case (hdr_idx)
                                2'd0: hi_nib <= bus.in_data[3:0];
                                2'd1: addr   <= ADDR_W'(hdr_val);
                                2'd2: hi_nib <= bus.in_data[3:0];
                                default: begin
                                    cnt     <= hdr_val;
                                    pay_idx <= '0;
                                    state   <= (hdr_val == 12'd0) ? S_CHK : S_PAY;
                                end
                            endcase
                        end else if (state == S_PAY) begin
                            case (pay_idx)
                                2'd0: begin
                                    b0      <= bus.in_data;
                                    pay_idx <= 2'd1;
                                end
                                2'd1: begin
                                    b1      <= bus.in_data;
                                    pay_idx <= 2'd2;
                                end
                                default: begin
                                    waddr_q <= addr;
                                    wdata_q <= INSTR_W'(word);
                                    we_q    <= 1'b1;
                                    rdy     <= 1'b0;
                                    pay_idx <= '0;
                                    state   <= S_WRITE;
                                end
                            endcase
                        end else begin
                            // Failed checksum only flags; words already written stay.
                            if (bus.in_data == chk) done_q <= 1'b1;
                            else                    err_q  <= 1'b1;
                            hold_q <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    addr  <= addr + ADDR_W'(1);
                    cnt   <= cnt - 12'd1;
                    state <= (cnt == 12'd1) ? S_CHK : S_PAY;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus
// random frames scored against a frame-level model of the expected writes.
module tb_imem_loader;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;
  localparam int TIMEOUT = 1024;
  localparam int W       = ADDR_W + INSTR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  imem_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus();

  imem_loader #(
    .SYNC_BYTE(8'hA5),
    .ADDR_W(ADDR_W),
    .INSTR_W(INSTR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   frame_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_we"},    32'(bus.imem_we),    0);
    check({pfx, "_addr"},  32'(bus.imem_addr),  0);
    check({pfx, "_wdata"}, 32'(bus.imem_wdata), 0);
    check({pfx, "_hold"},  32'(bus.cpu_hold),   0);
    check({pfx, "_done"},  32'(bus.done),       0);
    check({pfx, "_err"},   32'(bus.err),        0);
    check({pfx, "_rdy"},   32'(bus.in_ready),   0);
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.imem_we) begin
      check("rdy_in_write", 32'(bus.in_ready), 0);
      check("done_with_we", 32'(bus.done), 0);
      check("hold_in_write", 32'(bus.cpu_hold), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr", 32'(bus.imem_addr), 32'(mon_e[W-1:INSTR_W]));
        check("we_data", 32'(bus.imem_wdata), 32'(mon_e[INSTR_W-1:0]));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!acc && waited < 16) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic push_chk(input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int j = 1; j < frame_q.size(); j++) x ^= frame_q[j];
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask

  // reference model + frame driver
  task automatic run_frame(input int gap_max);
    int start;
    int cnt;
    int n;
    int waited;
    int exp_wait;
    logic [7:0]  x;
    logic [23:0] w;
    bit good;
    start = int'({frame_q[1][3:0], frame_q[2]});
    cnt   = int'({frame_q[3][3:0], frame_q[4]});
    for (int i = 0; i < cnt; i++) begin
      w = {frame_q[5 + 3*i], frame_q[6 + 3*i], frame_q[7 + 3*i]};
      exp_q.push_back({ADDR_W'((start + i) % (1 << ADDR_W)), INSTR_W'(w)});
    end
    n = frame_q.size();
    x = 8'h00;
    for (int j = 1; j < n - 1; j++) x ^= frame_q[j];
    good = (x == frame_q[n-1]);
    for (int j = 0; j < n; j++) begin
      send_byte(frame_q[j], waited);
      if (gap_max == 0) begin
        exp_wait = (j > 5 && j <= 5 + 3*cnt && (j - 5) % 3 == 0) ? 2 : 1;
        check("accept_cycles", 32'(waited), 32'(exp_wait));
      end
      if (j == 0) check("err_cleared_by_sync", 32'(bus.err), 0);
      if (j < n - 1) begin
        check("hold_in_frame", 32'(bus.cpu_hold), 1);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
    end
    check("done_pulse", 32'(bus.done), 32'(good));
    check("err_flag", 32'(bus.err), 32'(!good));
    check("hold_released", 32'(bus.cpu_hold), 0);
    idle(1);
    check("done_one_cycle", 32'(bus.done), 0);
    check("writes_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int cnt;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    check("ready_after_reset", 32'(bus.in_ready), 1);
    check("hold_after_reset", 32'(bus.cpu_hold), 0);

    // good frame at full rate
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h05, 8'h12, 8'h34, 8'h32};
    run_frame(0);

    // bad checksum, then a good frame clears err on its SYNC
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h05, 8'h12, 8'h34, 8'h33};
    run_frame(0);
    check("err_sticky", 32'(bus.err), 1);
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h05, 8'h12, 8'h34, 8'h32};
    run_frame(0);

    // address wrap with write backpressure
    frame_q = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02};
    push_chk(1'b0);
    run_frame(0);

    // junk before a zero-count frame
    send_byte(8'h00, waited);
    send_byte(8'hFF, waited);
    check("junk_no_hold", 32'(bus.cpu_hold), 0);
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(0);

    // timeout mid-header
    send_byte(8'hA5, waited);
    send_byte(8'h00, waited);
    bus.in_valid = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("tmo_err_early", 32'(bus.err), 0);
    check("tmo_hold_early", 32'(bus.cpu_hold), 1);
    @(posedge clk);
    #1;
    check("tmo_err", 32'(bus.err), 1);
    check("tmo_hold", 32'(bus.cpu_hold), 0);
    check("tmo_done", 32'(bus.done), 0);
    frame_q = '{8'hA5, 8'h01, 8'h23, 8'h00, 8'h01, 8'h7A, 8'hBC, 8'hDE};
    push_chk(1'b0);
    run_frame(0);

    // async reset between B1 and B2
    send_byte(8'hA5, waited);
    send_byte(8'h00, waited);
    send_byte(8'h20, waited);
    send_byte(8'h00, waited);
    send_byte(8'h01, waited);
    send_byte(8'h11, waited);
    send_byte(8'h22, waited);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h33, waited);
    send_byte(8'h44, waited);
    check("postrst_hold", 32'(bus.cpu_hold), 0);
    check("postrst_done", 32'(bus.done), 0);
    idle(2);
    check("postrst_no_writes", 32'(exp_q.size()), 0);

    // random frames
    for (int f = 0; f < 24; f++) begin
      cnt = $urandom_range(0, 5);
      frame_q = {};
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'($urandom_range(0, 255)));
      frame_q.push_back(8'($urandom_range(0, 255)));
      frame_q.push_back({4'($urandom_range(0, 15)), 4'h0});
      frame_q.push_back(8'(cnt));
      for (int k = 0; k < 3*cnt; k++) begin
        if ($urandom_range(0, 7) == 0) frame_q.push_back(8'hA5);
        else                           frame_q.push_back(8'($urandom_range(0, 255)));
      end
      push_chk($urandom_range(0, 3) == 0);
      run_frame($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
